// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid register and its counters.
`default_nettype none

package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam int CNT_W = 32;

   // Saturation point for the performance counters.
   localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// 32-bit saturating event counter with synchronous active-high reset.
`default_nettype none

module sat_counter
   import pipe_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != CNT_SAT)) begin
         count <= count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with skid buffer, flush, and optional perf counters.
// Define PIPE_SKID_PERF_EN to build the stall/flush counters; otherwise they read 0.
`default_nettype none

module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int                 DATA_W     = 64,
   parameter logic [DATA_W-1:0]  FLUSH_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] main_q, main_nxt;
   logic [DATA_W-1:0] skid_q, skid_nxt;
   logic              in_fire, out_fire;

   assign out_valid = (state != EMPTY);
   assign in_ready  = (state != TWO);
   assign out_data  = main_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               state_nxt = ONE;
               main_nxt  = in_data;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_nxt = in_data;
            end else if (in_fire) begin
               state_nxt = TWO;
               skid_nxt  = in_data;
            end else if (out_fire) begin
               state_nxt = EMPTY;
            end
         end
         TWO: begin
            if (out_fire) begin
               state_nxt = ONE;
               main_nxt  = skid_q;
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase
      // Squash overrides any transfer computed above.
      if (flush) begin
         state_nxt = EMPTY;
         main_nxt  = FLUSH_DATA;
         skid_nxt  = FLUSH_DATA;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= EMPTY;
         main_q <= FLUSH_DATA;
         skid_q <= FLUSH_DATA;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
      end
   end

`ifdef PIPE_SKID_PERF_EN
   sat_counter u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (out_valid & ~out_ready),
      .count (stall_cnt)
   );

   sat_counter u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush),
      .count (flush_cnt)
   );
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire
